fetch_pc_btb: RTL and testbench
===============================

Name: fetch_pc_btb

Overview:
- Instruction-fetch PC generator with an integrated direct-mapped branch target buffer (BTB) using 2-bit saturating counters.
- Sits directly upstream of the instruction cache. Drives the cache's word address each cycle and predicts the next PC.
- Because the cache read is synchronous, the PC and prediction are also registered so they line up with the instruction word delivered to ID one cycle later.
- Trained by the EX stage on branch resolution. Redirected by EX on mispredict.

Parameters:
- RESET_PC, 30'h0, word address loaded on reset.
- IDX_W, 6, BTB index width; number of entries = 2^IDX_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- stall_if  in  1  hold PC and ID-aligned outputs
- redirect_valid  in  1  EX mispredict/jump redirect
- redirect_pc  in  30  redirect word address [31:2]
- upd_valid  in  1  EX resolved a conditional branch this cycle
- upd_pc  in  30  word address of the resolved branch
- upd_taken  in  1  actual branch outcome
- upd_target  in  30  actual target word address
- pc_if  out  30  current fetch word address, to instruction cache addr[31:2]
- pc_id  out  30  PC of the instruction the cache outputs this cycle
- pred_taken_id  out  1  prediction made for pc_id
- pred_target_id  out  30  predicted target for pc_id
- inst_valid_id  out  1  cache data this cycle is a real instruction (not a bubble)

Behaviour:
- Reset is synchronous, sampled on posedge clk with rst_n=0. Values after reset:
  - pc_if=RESET_PC, pc_id=0, pred_taken_id=0, pred_target_id=0, inst_valid_id=0.
  - All BTB valid bits=0, all counters=01 (weakly not-taken).
  - Reset overrides every other input, including mid-update and mid-redirect.
- BTB entry fields: valid, tag = pc[31:IDX_W+2], target[31:2], cnt[1:0]. Index = pc[IDX_W+1:2].
- Lookup is combinational on pc_if:
  - hit = valid & tag match.
  - pred = hit & cnt[1].
- Next-PC priority, applied at each posedge:
  1. redirect_valid: pc_if<=redirect_pc (wins even when stall_if=1).
  2. stall_if: pc_if held.
  3. pred: pc_if<=BTB target.
  4. otherwise pc_if<=pc_if+1, modulo 2^30 (30'h3FFFFFFF wraps to 0).
- ID-aligned registers:
  - redirect_valid: inst_valid_id<=0, pred_taken_id<=0; pc_id and pred_target_id don't-care.
  - else stall_if: all hold.
  - else: pc_id<=pc_if, pred_taken_id<=pred, pred_target_id<=target of hit entry (0 on miss), inst_valid_id<=1.
- Counter update, on upd_valid at posedge, indexed by upd_pc:
  - hit & taken: cnt saturating +1 (max 11); target<=upd_target.
  - hit & not taken: cnt saturating -1 (min 00); target kept.
  - miss & taken: allocate and overwrite the slot: valid=1, tag, target, cnt=10 (weakly taken).
  - miss & not taken: no change.
- Update is not gated by stall_if.
- Same-cycle lookup and update on the same index: the lookup uses the pre-update entry. The new state is visible from the next cycle. No bypass.
- Latency:
  - Prediction is zero-cycle on pc_if.
  - Training is visible to lookups one cycle after upd_valid.
  - Redirect is visible on pc_if one cycle after redirect_valid.
- Aliasing: a different tag at the same index is a miss. A taken update replaces the entry; no partial tag matching.

Decomposition:
- Package fetch_pkg holds:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Default RESET_PC.
  - Width constants PC_W=30 and TAG_W=30-IDX_W.
  - BTB entry struct typedef.
- One sub-module, btb_table, contains the entry array, combinational lookup, and counter update logic.
- The top level holds the PC register, next-PC mux and ID-aligned registers.

Test Plan:
- Reset, then 4 unstalled cycles -> pc_if = 0,1,2,3,4; pc_id lags by one; inst_valid_id=0 only in the first post-reset cycle; pred_taken_id=0 throughout.
- Train the backward branch at word 5 with target word 3: upd_valid, upd_pc=5, upd_taken=1, upd_target=3 -> next time pc_if=5, the following pc_if=3 and pred_taken_id=1 with pred_target_id=3 aligned to pc_id=5.
- Counter hysteresis at pc=5: after 2 taken updates, cnt=11; 1 not-taken still predicts taken; a 2nd not-taken -> falls through to pc 6; 3 more not-taken keep cnt=00 (saturation).
- Alias: train pc=5 taken, then fetch pc=5+2^IDX_W -> miss, sequential fetch. A taken update at the alias replaces the entry -> pc=5 now misses.
- Redirect with stall: stall_if=1 and redirect_valid=1, redirect_pc=30'h100 -> pc_if=30'h100 next cycle, inst_valid_id=0. Separately, pc_if=30'h3FFFFFFF unstalled -> wraps to 0.
- Reset mid-operation: assert rst_n=0 during a redirect and an update -> pc_if=RESET_PC, all BTB entries invalid (a previously trained pc=5 now predicts not-taken).

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                            |
// | Shared constants, BTB counter encodings and entry payload type for   |
// | the fetch PC generator and its branch target buffer.                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package fetch_pkg;

  // Word-address width (byte address bits [31:2])
  localparam int PC_W      = 30;
  localparam int DEF_IDX_W = 6;
  localparam int TAG_W     = PC_W - DEF_IDX_W;

  localparam logic [PC_W-1:0] DEF_RESET_PC = 30'h0;

  // 2-bit saturating counter encodings; cnt[1] is the taken prediction
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Per-entry payload. The tag lives in a separate array because its
  // width depends on the per-instance index width.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] target;
    logic [1:0]      cnt;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_btb_btb_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btb_table                                                            |
// | Direct-mapped BTB: entry storage, combinational lookup and           |
// | 2-bit saturating counter training.                                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module btb_table
  import fetch_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lkp_pc_i,
  output logic            lkp_pred_o,
  output logic [PC_W-1:0] lkp_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i
);

  localparam int c_ENTRIES = 1 << IDX_W;
  localparam int c_TAG_W   = PC_W - IDX_W;

  btb_entry_t         entry_q [c_ENTRIES];
  logic [c_TAG_W-1:0] tag_q   [c_ENTRIES];

  logic [IDX_W-1:0]   w_lkp_idx;
  logic [c_TAG_W-1:0] w_lkp_tag;
  logic               w_lkp_hit;
  logic [IDX_W-1:0]   w_upd_idx;
  logic [c_TAG_W-1:0] w_upd_tag;
  logic               w_upd_hit;

  assign w_lkp_idx = lkp_pc_i[IDX_W-1:0];
  assign w_lkp_tag = lkp_pc_i[PC_W-1:IDX_W];
  assign w_upd_idx = upd_pc_i[IDX_W-1:0];
  assign w_upd_tag = upd_pc_i[PC_W-1:IDX_W];

  // Lookup reads registered state, so a same-cycle update is not bypassed
  assign w_lkp_hit    = entry_q[w_lkp_idx].valid && (tag_q[w_lkp_idx] == w_lkp_tag);
  assign lkp_pred_o   = w_lkp_hit && entry_q[w_lkp_idx].cnt[1];
  assign lkp_target_o = w_lkp_hit ? entry_q[w_lkp_idx].target : '0;

  assign w_upd_hit = entry_q[w_upd_idx].valid && (tag_q[w_upd_idx] == w_upd_tag);

  // Train on resolved branches; a taken miss evicts whatever occupies the slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        entry_q[i] <= '{valid: 1'b0, target: '0, cnt: WNT};
        tag_q[i]   <= '0;
      end
    end else if (upd_valid_i) begin
      if (w_upd_hit) begin
        if (upd_taken_i) begin
          entry_q[w_upd_idx].cnt    <= sat_inc(entry_q[w_upd_idx].cnt);
          entry_q[w_upd_idx].target <= upd_target_i;
        end else begin
          entry_q[w_upd_idx].cnt    <= sat_dec(entry_q[w_upd_idx].cnt);
        end
      end else if (upd_taken_i) begin
        entry_q[w_upd_idx] <= '{valid: 1'b1, target: upd_target_i, cnt: WT};
        tag_q[w_upd_idx]   <= w_upd_tag;
      end
    end
  end

endmodule : btb_table
`default_nettype wire

// File: rtl/fetch_pc_btb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pc_btb                                                         |
// | Fetch PC generator with BTB prediction; registers PC/prediction so   |
// | they align with the synchronous I-cache output seen by ID.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fetch_pc_btb
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int              IDX_W    = DEF_IDX_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_if,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  output logic [PC_W-1:0] pc_if,
  output logic [PC_W-1:0] pc_id,
  output logic            pred_taken_id,
  output logic [PC_W-1:0] pred_target_id,
  output logic            inst_valid_id
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_id_q, pc_id_d;
  logic            pred_taken_q, pred_taken_d;
  logic [PC_W-1:0] pred_target_q, pred_target_d;
  logic            inst_valid_q, inst_valid_d;

  logic            w_pred;
  logic [PC_W-1:0] w_target;

  btb_table #(
    .IDX_W (IDX_W)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lkp_pc_i     (pc_q),
    .lkp_pred_o   (w_pred),
    .lkp_target_o (w_target),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_taken_i  (upd_taken),
    .upd_target_i (upd_target)
  );

  // Next-PC mux (redirect > stall > predicted target > sequential) and ID alignment
  always_comb begin
    pc_d          = pc_q;
    pc_id_d       = pc_id_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    inst_valid_d  = inst_valid_q;
    if (redirect_valid) begin
      // Redirect overrides stall; the in-flight fetch becomes a bubble
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      pred_taken_d = 1'b0;
    end else if (!stall_if) begin
      pc_id_d       = pc_q;
      pred_taken_d  = w_pred;
      pred_target_d = w_target;
      inst_valid_d  = 1'b1;
      pc_d          = w_pred ? w_target : pc_q + 30'd1;
    end
  end

  // PC and ID-aligned state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      pc_id_q       <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      inst_valid_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pc_id_q       <= pc_id_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      inst_valid_q  <= inst_valid_d;
    end
  end

  assign pc_if          = pc_q;
  assign pc_id          = pc_id_q;
  assign pred_taken_id  = pred_taken_q;
  assign pred_target_id = pred_target_q;
  assign inst_valid_id  = inst_valid_q;

endmodule : fetch_pc_btb
`default_nettype wire

// File: tb/tb_fetch_pc_btb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_pc_btb                                                      |
// | Directed bench for fetch_pc_btb with a behavioural reference model   |
// | feeding an expected-result queue.                                    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_fetch_pc_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        upd_valid;
  logic [29:0] upd_pc;
  logic        upd_taken;
  logic [29:0] upd_target;
  logic [29:0] pc_if;
  logic [29:0] pc_id;
  logic        pred_taken_id;
  logic [29:0] pred_target_id;
  logic        inst_valid_id;

  int n_cmp = 0;
  int n_err = 0;

  fetch_pc_btb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_if       (stall_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .pc_if          (pc_if),
    .pc_id          (pc_id),
    .pred_taken_id  (pred_taken_id),
    .pred_target_id (pred_target_id),
    .inst_valid_id  (inst_valid_id)
  );

  always #5 clk = ~clk;

  // Expected post-edge output set; dc marks pc_id/pred_target_id as don't-care
  typedef struct {
    logic [29:0] pc_if;
    logic [29:0] pc_id;
    logic        pt;
    logic [29:0] ptg;
    logic        iv;
    logic        dc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (64-entry BTB)
  logic [29:0] m_pc, m_pc_id, m_ptg;
  logic        m_pt, m_iv, m_dc;
  bit          m_v   [64];
  int unsigned m_tag [64];
  logic [29:0] m_tgt [64];
  int          m_cnt [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_step(input logic rn, st, rv, input logic [29:0] rp,
                            input logic uv, input logic [29:0] up,
                            input logic ut, input logic [29:0] utg);
    int          idx, ui;
    bit          hit, pred, uhit;
    logic [29:0] tg;
    if (!rn) begin
      m_pc = 30'h0; m_pc_id = 30'h0; m_pt = 1'b0; m_ptg = 30'h0; m_iv = 1'b0; m_dc = 1'b0;
      for (int i = 0; i < 64; i++) begin
        m_v[i] = 0; m_cnt[i] = 1; m_tag[i] = 0; m_tgt[i] = 30'h0;
      end
    end else begin
      idx  = int'(m_pc % 64);
      hit  = m_v[idx] && (m_tag[idx] == int'(m_pc / 64));
      pred = hit && (m_cnt[idx] >= 2);
      tg   = hit ? m_tgt[idx] : 30'h0;
      if (rv) begin
        m_iv = 1'b0; m_pt = 1'b0; m_dc = 1'b1; m_pc = rp;
      end else if (!st) begin
        m_pc_id = m_pc; m_pt = pred; m_ptg = tg; m_iv = 1'b1; m_dc = 1'b0;
        m_pc = pred ? tg : 30'((int'(m_pc) + 1) % (1 << 30));
      end
      if (uv) begin
        ui   = int'(up % 64);
        uhit = m_v[ui] && (m_tag[ui] == int'(up / 64));
        if (uhit) begin
          if (ut) begin
            m_cnt[ui] = (m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1;
            m_tgt[ui] = utg;
          end else begin
            m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
          end
        end else if (ut) begin
          m_v[ui] = 1; m_tag[ui] = int'(up / 64); m_tgt[ui] = utg; m_cnt[ui] = 2;
        end
      end
    end
    exp_q.push_back('{pc_if: m_pc, pc_id: m_pc_id, pt: m_pt, ptg: m_ptg, iv: m_iv, dc: m_dc});
  endtask

  // One clock: drive inputs, enqueue expectation, sample #1 after the edge
  task automatic step(input logic rn, st, rv, input logic [29:0] rp,
                      input logic uv, input logic [29:0] up,
                      input logic ut, input logic [29:0] utg);
    exp_t e;
    rst_n = rn; stall_if = st; redirect_valid = rv; redirect_pc = rp;
    upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
    model_step(rn, st, rv, rp, uv, up, ut, utg);
    @(posedge clk);
    #1;
    rst_n = 1'b1; stall_if = 1'b0; redirect_valid = 1'b0; upd_valid = 1'b0;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk("pc_if", {2'b0, pc_if}, {2'b0, e.pc_if});
      chk("inst_valid_id", {31'b0, inst_valid_id}, {31'b0, e.iv});
      chk("pred_taken_id", {31'b0, pred_taken_id}, {31'b0, e.pt});
      if (!e.dc) begin
        chk("pc_id", {2'b0, pc_id}, {2'b0, e.pc_id});
        chk("pred_target_id", {2'b0, pred_target_id}, {2'b0, e.ptg});
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 30'h0, 0, 30'h0, 0, 30'h0);
  endtask
  task automatic redir(input logic [29:0] a);
    step(1, 0, 1, a, 0, 30'h0, 0, 30'h0);
  endtask
  task automatic train(input logic [29:0] a, input logic t, input logic [29:0] tg);
    step(1, 0, 0, 30'h0, 1, a, t, tg);
  endtask
  task automatic expect_pc(input string tag, input logic [29:0] v);
    chk(tag, {2'b0, pc_if}, {2'b0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall_if = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 30'h0, 0, 30'h0, 0, 30'h0);
    step(0, 0, 0, 30'h0, 0, 30'h0, 0, 30'h0);
    expect_pc("reset_pc_if", 30'h0);
    chk("reset_inst_valid", {31'b0, inst_valid_id}, 32'd0);

    // Sequential walk 0..4; first cycle is a bubble
    run(4);
    expect_pc("walk_pc4", 30'h4);
    chk("walk_pc_id3", {2'b0, pc_id}, 32'd3);

    // Train backward branch 5 -> 3 while fetching 4; lookup at 5 sees it
    train(30'h5, 1, 30'h3);
    expect_pc("trained_at5", 30'h5);
    run(1);
    expect_pc("pred_to3", 30'h3);
    chk("pred_taken_at5", {31'b0, pred_taken_id}, 32'd1);
    chk("pred_target_at5", {2'b0, pred_target_id}, 32'd3);
    chk("pred_pc_id5", {2'b0, pc_id}, 32'd5);

    // Hysteresis: second taken -> 11; one not-taken still predicts
    train(30'h5, 1, 30'h3);
    train(30'h5, 0, 30'h0);
    redir(30'h5);
    run(1);
    expect_pc("hyst_10_taken", 30'h3);
    train(30'h5, 0, 30'h0);
    redir(30'h5);
    run(1);
    expect_pc("hyst_01_fall", 30'h6);
    train(30'h5, 0, 30'h0);
    train(30'h5, 0, 30'h0);
    train(30'h5, 0, 30'h0);
    // Saturated at 00: a single taken reaches only 01
    train(30'h5, 1, 30'h3);
    redir(30'h5);
    run(1);
    expect_pc("sat_00_plus1", 30'h6);
    train(30'h5, 1, 30'h3);
    redir(30'h5);
    run(1);
    expect_pc("sat_back_taken", 30'h3);

    // Alias at 5+64 misses, then a taken update there evicts pc=5
    redir(30'd69);
    run(1);
    expect_pc("alias_miss", 30'd70);
    train(30'd69, 1, 30'h200);
    redir(30'h5);
    run(1);
    expect_pc("alias_evicted", 30'h6);
    redir(30'd69);
    run(1);
    expect_pc("alias_hit", 30'h200);

    // Redirect wins over stall; stall then holds everything
    step(1, 1, 1, 30'h100, 0, 30'h0, 0, 30'h0);
    expect_pc("redir_stall", 30'h100);
    chk("redir_bubble", {31'b0, inst_valid_id}, 32'd0);
    step(1, 1, 0, 30'h0, 0, 30'h0, 0, 30'h0);
    expect_pc("stall_hold", 30'h100);
    run(2);

    // Wrap at top of address space
    redir(30'h3FFFFFFF);
    run(1);
    expect_pc("wrap", 30'h0);

    // Reset mid-redirect and mid-update clears the trained entry
    train(30'h5, 1, 30'h3);
    train(30'h5, 1, 30'h3);
    step(0, 0, 1, 30'h123, 1, 30'h5, 1, 30'h3);
    expect_pc("midrst_pc", 30'h0);
    chk("midrst_iv", {31'b0, inst_valid_id}, 32'd0);
    chk("midrst_pc_id", {2'b0, pc_id}, 32'd0);
    redir(30'h5);
    run(1);
    expect_pc("midrst_btb_clear", 30'h6);
    chk("midrst_no_pred", {31'b0, pred_taken_id}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_pc_btb
`default_nettype wire
